// File: rtl/pll_pkg.sv
// Shared PLL definitions: lock-detector state encoding and default window/hysteresis settings.
package pll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } pll_state_t;

    localparam int PLL_WIN_LOG2   = 4;
    localparam int PLL_TOL        = 1;
    localparam int PLL_LOCK_CNT   = 4;
    localparam int PLL_UNLOCK_CNT = 2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by an edge register; emits a registered one-cycle pulse
// for each rising edge of an asynchronous input.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: counts feedback edges per reference window and declares lock with hysteresis.
// Optional stuck-acquisition timeout is enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_lock_detect import pll_pkg::*; #(
    parameter int WIN_LOG2   = PLL_WIN_LOG2,
    parameter int TOL        = PLL_TOL,
    parameter int LOCK_CNT   = PLL_LOCK_CNT,
    parameter int UNLOCK_CNT = PLL_UNLOCK_CNT
`ifdef PLL_LOCK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                en,
    input  logic                ref_in,
    input  logic                fb_in,
    output logic                lock,
    output logic                lock_lost,
    output logic                win_done,
    output logic [WIN_LOG2+1:0] freq_err,
    output logic [1:0]          state
`ifdef PLL_LOCK_TIMEOUT_EN
    ,
    output logic                timeout
`endif
);
    localparam int CW = WIN_LOG2 + 2;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    localparam logic [CW-1:0]       WIN_LEN  = CW'(2 ** WIN_LOG2);
    localparam logic [CW-1:0]       TOL_V    = CW'(TOL);
    localparam logic [CW-1:0]       FB_MAX   = '1;
    localparam logic [CW-1:0]       CW_ONE   = CW'(1);
    localparam logic [WIN_LOG2-1:0] REF_LAST = '1;
    localparam logic [WIN_LOG2-1:0] REF_ONE  = WIN_LOG2'(1);
    localparam logic [GW-1:0]       G_LAST   = GW'(LOCK_CNT - 1);
    localparam logic [GW-1:0]       G_ONE    = GW'(1);
    localparam logic [BW-1:0]       B_LAST   = BW'(UNLOCK_CNT - 1);
    localparam logic [BW-1:0]       B_ONE    = BW'(1);

    pll_state_t          st;
    logic                ref_p, fb_p;
    logic [WIN_LOG2-1:0] ref_cnt;
    logic [CW-1:0]       fb_cnt, fb_total, err, err_mag;
    logic [GW-1:0]       good_cnt;
    logic [BW-1:0]       bad_cnt;
    logic                close, good;

    edge_sync u_ref_sync (.clk(clkin), .rst_n(rst), .din(ref_in), .rise(ref_p));
    edge_sync u_fb_sync  (.clk(clkin), .rst_n(rst), .din(fb_in),  .rise(fb_p));

    assign state = st;

    // An fb pulse coincident with the closing ref pulse belongs to the closing window.
    always_comb begin
        fb_total = fb_cnt;
        if (fb_p && fb_cnt != FB_MAX) fb_total = fb_cnt + CW_ONE;
        err     = fb_total - WIN_LEN;
        err_mag = err[CW-1] ? (~err + CW_ONE) : err;
        good    = (err_mag <= TOL_V);
        close   = en && (st != ST_IDLE) && ref_p && (ref_cnt == REF_LAST);
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            st        <= ST_IDLE;
            lock      <= 1'b0;
            lock_lost <= 1'b0;
            win_done  <= 1'b0;
            freq_err  <= '0;
            ref_cnt   <= '0;
            fb_cnt    <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            win_done  <= 1'b0;
            lock_lost <= 1'b0;
            if (!en) begin
                // Partial window is discarded; freq_err keeps the last result.
                st       <= ST_IDLE;
                lock     <= 1'b0;
                ref_cnt  <= '0;
                fb_cnt   <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else if (st == ST_IDLE) begin
                st       <= ST_ACQ;
                ref_cnt  <= '0;
                fb_cnt   <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else if (close) begin
                ref_cnt  <= '0;
                fb_cnt   <= '0;
                win_done <= 1'b1;
                freq_err <= err;
                case (st)
                    ST_ACQ: begin
                        if (!good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == G_LAST) begin
                            st       <= ST_LOCKED;
                            lock     <= 1'b1;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + G_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (good) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == B_LAST) begin
                            st        <= ST_ACQ;
                            lock      <= 1'b0;
                            lock_lost <= 1'b1;
                            good_cnt  <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + B_ONE;
                        end
                    end
                    default: begin
                        st   <= ST_IDLE;
                        lock <= 1'b0;
                    end
                endcase
            end else begin
                if (ref_p) ref_cnt <= ref_cnt + REF_ONE;
                fb_cnt <= fb_total;
            end
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    logic [TW-1:0] tmo_cnt;

    // Counts only while acquiring; reaching lock restarts it, dropping en clears the flag.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (!en) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (st == ST_IDLE || lock) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != T_MAX) begin
            tmo_cnt <= tmo_cnt + T_ONE;
            if (tmo_cnt == T_LAST) timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Self-checking bench for pll_lock_detect: NCO-driven ref/fb pins, window-level model feeding
// an expected queue that is compared at every win_done.
module tb_pll_lock_detect;
    logic       clkin = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       ref_in = 1'b0;
    logic       fb_in = 1'b0;
    logic       lock, lock_lost, win_done;
    logic [5:0] freq_err;
    logic [1:0] state;
`ifdef PLL_LOCK_TIMEOUT_EN
    logic       timeout;
`endif

    int total = 0;
    int bad = 0;

`ifdef PLL_LOCK_TIMEOUT_EN
    pll_lock_detect #(.TIMEOUT_CYC(1000)) dut (
`else
    pll_lock_detect dut (
`endif
        .clkin(clkin), .rst(rst), .en(en), .ref_in(ref_in), .fb_in(fb_in),
        .lock(lock), .lock_lost(lock_lost), .win_done(win_done),
        .freq_err(freq_err), .state(state)
`ifdef PLL_LOCK_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    // clock / reset
    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pin generators: phase accumulators, 1024 units per period, square wave
    logic gen_on = 1'b0;
    int   ref_inc = 0, fb_inc = 0, ref_ph = 0, fb_ph = 0;

    initial forever begin
        @(negedge clkin);
        if (!gen_on) begin
            ref_in = 1'b0;
            fb_in  = 1'b0;
        end else begin
            ref_ph = (ref_ph + ref_inc) % 1024;
            fb_ph  = (fb_ph + fb_inc) % 1024;
            ref_in = (ref_inc != 0) && (ref_ph < 512);
            fb_in  = (fb_inc != 0) && (fb_ph < 512);
        end
    end

    // window model working on raw pin edges; pushes {lost, lock, state, err}
    logic [9:0] exp_q[$];
    logic       m_active = 1'b0;
    logic       ref_prev = 1'b0, fb_prev = 1'b0;
    int         m_ref = 0, m_fb = 0, m_good = 0, m_bad = 0, m_state = 1;
    logic       m_lock = 1'b0;

    task automatic model_clear();
        m_ref = 0; m_fb = 0; m_good = 0; m_bad = 0; m_state = 1; m_lock = 1'b0;
    endtask

    initial forever begin
        logic rr, fr, lost, g;
        int   tot, e;
        logic [5:0] e6;
        @(posedge clkin);
        rr = ref_in & ~ref_prev;
        fr = fb_in & ~fb_prev;
        ref_prev = ref_in;
        fb_prev  = fb_in;
        if (m_active) begin
            tot = m_fb + (fr ? 1 : 0);
            if (tot > 63) tot = 63;
            if (rr && m_ref == 15) begin
                e    = tot - 16;
                e6   = e[5:0];
                g    = (e >= -1) && (e <= 1);
                lost = 1'b0;
                if (m_state == 1) begin
                    if (!g) m_good = 0;
                    else if (m_good + 1 == 4) begin
                        m_state = 2; m_lock = 1'b1; m_good = 0; m_bad = 0;
                    end else m_good++;
                end else begin
                    if (g) m_bad = 0;
                    else if (m_bad + 1 == 2) begin
                        m_state = 1; m_lock = 1'b0; lost = 1'b1; m_good = 0; m_bad = 0;
                    end else m_bad++;
                end
                exp_q.push_back({lost, m_lock, 2'(m_state), e6});
                m_ref = 0;
                m_fb  = 0;
            end else begin
                if (rr) m_ref++;
                m_fb = tot;
            end
        end
    end

    // scoreboard / output monitor
    int cyc = 0, wd_last = 0, wd_gap = 0, wd_seen = 0, lost_seen = 0;
    always @(posedge clkin) cyc++;

    initial forever begin
        logic [9:0] e;
        @(negedge clkin);
        if (lock_lost) lost_seen++;
        if (win_done) begin
            wd_seen++;
            wd_gap  = cyc - wd_last;
            wd_last = cyc;
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("wd_err", 32'(freq_err), 32'(e[5:0]));
                chk("wd_state", 32'(state), 32'(e[7:6]));
                chk("wd_lock", 32'(lock), 32'(e[8]));
                chk("wd_lost", 32'(lock_lost), 32'(e[9]));
            end
        end
    end

    // driver tasks
    task automatic wait_windows(input int n);
        int target, k;
        target = wd_seen + n;
        for (k = 0; k < n * 200; k++) begin
            @(posedge clkin);
            if (wd_seen >= target) break;
        end
        #1;
        if (wd_seen < target) chk("win_timeout", 32'(wd_seen), 32'(target));
    endtask

    task automatic stop_gens();
        @(posedge clkin); #1;
        gen_on   = 1'b0;
        m_active = 1'b0;
        repeat (8) @(posedge clkin);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start_run(input int ri, input int fi);
        stop_gens();
        en = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        en = 1'b1;
        repeat (3) @(posedge clkin);
        #1;
        model_clear();
        ref_ph = 0; fb_ph = 0; ref_inc = ri; fb_inc = fi;
        gen_on   = 1'b1;
        m_active = 1'b1;
    endtask

    initial begin
        int lost0;
        repeat (3) @(posedge clkin);
        #1;
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ferr", 32'(freq_err), 32'd0);
        chk("rst_wd", 32'(win_done), 32'd0);
        rst = 1'b1;
        @(posedge clkin); #1;
        chk("idle_state", 32'(state), 32'd0);
        en = 1'b1;
        @(posedge clkin); #1;
        chk("acq_entry", 32'(state), 32'd1);

        // lock acquisition, in phase, period 8
        start_run(128, 128);
        wait_windows(3);
        chk("lock_after3", 32'(lock), 32'd0);
        wait_windows(1);
        chk("lock_after4", 32'(lock), 32'd1);
        chk("state_locked", 32'(state), 32'd2);
        chk("win_period", 32'(wd_gap), 32'd128);

        // loss of lock: fb stuck low
        lost0 = lost_seen;
        fb_inc = 0;
        wait_windows(3);
        chk("lost_pulses", 32'(lost_seen - lost0), 32'd1);
        chk("unlock", 32'(lock), 32'd0);
        chk("unlock_state", 32'(state), 32'd1);
        chk("stuck_err", 32'(freq_err), 32'h30);

        // frequency mismatch, fb period ~6
        start_run(128, 171);
        wait_windows(6);
        chk("mis_lock", 32'(lock), 32'd0);
        chk("mis_state", 32'(state), 32'd1);

        // tolerance edges: 17 and 18 fb edges per window
        start_run(128, 136);
        wait_windows(5);
        chk("tol17_lock", 32'(lock), 32'd1);
        chk("tol17_err", 32'(freq_err), 32'd1);
        start_run(128, 144);
        wait_windows(6);
        chk("tol18_lock", 32'(lock), 32'd0);
        chk("tol18_err", 32'(freq_err), 32'd2);

        // en dropped for one cycle mid-window while locked
        start_run(128, 128);
        wait_windows(4);
        repeat ($urandom_range(30, 60)) @(posedge clkin);
        #1;
        lost0 = lost_seen;
        en = 1'b0;
        @(posedge clkin); #1;
        chk("en_lock", 32'(lock), 32'd0);
        chk("en_state", 32'(state), 32'd0);
        chk("en_hold_err", 32'(freq_err), 32'd0);
        en = 1'b1;
        @(posedge clkin); #1;
        chk("en_no_lost", 32'(lost_seen - lost0), 32'd0);

        // relock needs four fresh windows
        start_run(128, 128);
        wait_windows(3);
        chk("relock_3", 32'(lock), 32'd0);
        wait_windows(1);
        chk("relock_4", 32'(lock), 32'd1);

        // asynchronous reset mid-window
        repeat ($urandom_range(30, 60)) @(posedge clkin);
        #2;
        m_active = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_lock", 32'(lock), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_ferr", 32'(freq_err), 32'd0);
        @(posedge clkin); #1;
        rst = 1'b1;
        start_run(128, 128);
        wait_windows(4);
        chk("rst_relock", 32'(lock), 32'd1);

`ifdef PLL_LOCK_TIMEOUT_EN
        start_run(128, 0);
        repeat (985) @(posedge clkin);
        #1;
        chk("tmo_early", 32'(timeout), 32'd0);
        repeat (20) @(posedge clkin);
        #1;
        chk("tmo_set", 32'(timeout), 32'd1);
        stop_gens();
        chk("tmo_sticky", 32'(timeout), 32'd1);
        en = 1'b0;
        @(posedge clkin); #1;
        chk("tmo_clear", 32'(timeout), 32'd0);
        en = 1'b1;
`endif

        stop_gens();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/pll_lock_detect.md
Name: pll_lock_detect

Overview:
- Digital lock detector at the receiving end of the PLL feedback loop.
- Samples the pre-divided reference and the feedback-divider output in the `clkin` domain.
- Counts rising edges of each over a fixed reference window, compares the counts, and declares lock or loss of lock with hysteresis.
- Drives `lock` to the system and reports a signed per-window frequency error for debug and calibration.

Parameters:
- WIN_LOG2, 4, window length = 2^WIN_LOG2 reference rising edges.
- TOL, 1, max |fb_count − window length| for a window to be "good".
- LOCK_CNT, 4, consecutive good windows required to assert lock.
- UNLOCK_CNT, 2, consecutive bad windows required to drop lock.
- CW, WIN_LOG2+2, counter and freq_err width (derived, not overridden).

Ports:
- clkin  in  1  sampling clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  detector enable; low forces IDLE.
- ref_in  in  1  pre-divided reference, asynchronous to clkin, frequency < clkin/4.
- fb_in  in  1  feedback-divider output, asynchronous to clkin, frequency < clkin/4.
- lock  out  1  registered lock flag.
- lock_lost  out  1  one-cycle pulse when LOCKED falls back to ACQ.
- win_done  out  1  one-cycle pulse at each window close.
- freq_err  out  CW  signed (fb edges − 2^WIN_LOG2), updated at win_done.
- state  out  2  FSM state: 0 IDLE, 1 ACQ, 2 LOCKED.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, all counters and synchronizers 0.
- Input path:
  - ref_in and fb_in each pass through a 2-flop synchronizer plus an edge register.
  - Rising-edge pulse appears 3 clkin cycles after the pin edge.
- Counting:
  - ref_cnt counts ref pulses 0..2^WIN_LOG2−1.
  - fb_cnt counts fb pulses and saturates at 2^CW−1; no wrap.
- Window close: the cycle with a ref pulse while ref_cnt = 2^WIN_LOG2−1.
  - An fb pulse in the same cycle is counted in the closing window.
  - ref_cnt and fb_cnt restart at 0 next cycle.
- Cycle after close:
  - win_done=1.
  - freq_err = fb_cnt − 2^WIN_LOG2 (two's complement, CW bits).
  - FSM update takes effect the same cycle as win_done.
- good = |freq_err| ≤ TOL.
- FSM:
  - IDLE: counters held at 0. en=1 → ACQ next cycle.
  - ACQ:
    - Good window: good_cnt+1.
    - Bad window: good_cnt=0.
    - When good_cnt reaches LOCK_CNT → LOCKED, lock=1, bad_cnt=0.
  - LOCKED:
    - Bad window: bad_cnt+1.
    - Good window: bad_cnt=0.
    - When bad_cnt reaches UNLOCK_CNT → ACQ, lock=0, lock_lost=1 for one cycle, good_cnt=0.
- en deasserted in any state:
  - Next cycle state=IDLE, lock=0.
  - Counters cleared; partial window discarded.
  - No lock_lost pulse and no win_done.
  - freq_err holds its last value.
- fb_in stuck: each window closes with freq_err = −2^WIN_LOG2.
- ref_in stuck: no window ever closes; lock holds its current value (covered by optional timeout).
- Reset mid-window: immediate clear; first window after release starts from 0.

Optional Feature:
- Macro: PLL_LOCK_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 4096) and output timeout (1 bit, sticky).
  - A free-running clkin counter runs while state≠IDLE and lock=0.
  - When it reaches TIMEOUT_CYC, timeout=1.
  - timeout clears only on rst or when en goes low.
  - Entering LOCKED resets the counter.
- Undefined: no port, no counter; behaviour otherwise identical.

Decomposition:
- Shared package pll_pkg:
  - 2-bit state typedef and encodings (IDLE/ACQ/LOCKED).
  - Default WIN_LOG2/TOL/LOCK_CNT/UNLOCK_CNT constants, also used by the top-level PLL wrapper.
- Sub-module: edge_sync (2-flop synchronizer plus rising-edge pulse), instantiated twice.

Test Plan:
- Lock acquisition (defaults): en=1, ref and fb both period 8 clkin, in phase → win_done every 128 cycles, freq_err=0, lock rises with the 4th win_done, state=2.
- Frequency mismatch: ref period 8, fb period 6 → freq_err = +5 or +6 every window, lock never asserts, state stays 1.
- Tolerance edge: fb delivering 17 edges/window → freq_err=+1, good, lock after 4 windows; 18 edges/window → freq_err=+2, never locks.
- Loss of lock: after lock, hold fb_in=0 → freq_err=−16 (0x30 in 6 bits); lock falls and lock_lost pulses once with the 2nd bad win_done; state returns to 1.
- en/reset mid-operation: drop en for 1 cycle mid-window while locked → next cycle lock=0, state=0, no lock_lost. Assert rst mid-window → all outputs 0 immediately. Relock requires 4 fresh full windows.
- Timeout (macro defined, TIMEOUT_CYC=1000): ref period 8, fb stuck low → timeout=1 at cycle 1000 after ACQ entry; stays set until en=0.
